// File: rtl/endec_host_pkg.sv
// Shared types, beat counts and config-word layout for the endec stream host.
`include "param_def.sv"
package endec_host_pkg;

    localparam int POLY_W  = `MAX_CONSTRAINT_LENGTH * `MAX_CODE_RATE;
    localparam int FRAME_W = 384;
    localparam int BEAT_W  = 32;

    localparam logic [3:0] ENC_TX_BEATS = 4'd4;
    localparam logic [3:0] DEC_TX_BEATS = 4'd12;
    localparam logic [3:0] ENC_RX_BEATS = 4'd12;
    localparam logic [3:0] DEC_RX_BEATS = 4'd4;

    localparam int CFG_MODE_BIT = 29;
    localparam int CFG_RATE_BIT = 28;
    localparam int CFG_POLY_MSB = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_PAYLOAD,
        ST_RESP,
        ST_DONE
    } state_e;

    function automatic logic [BEAT_W-1:0] cfg_word(input logic mode, input logic rate,
                                                   input logic [POLY_W-1:0] poly);
        logic [BEAT_W-1:0] w;
        w = '0;
        w[CFG_MODE_BIT] = mode;
        w[CFG_RATE_BIT] = rate;
        w[CFG_POLY_MSB -: POLY_W] = poly;
        return w;
    endfunction

    // Beat k of the low 'span' bits of f, most significant beat first.
    function automatic logic [BEAT_W-1:0] frame_beat(input logic [FRAME_W-1:0] f,
                                                     input int span, input logic [3:0] k);
        logic [FRAME_W-1:0] sh;
        sh = f >> (span - BEAT_W * (int'(k) + 1));
        return sh[BEAT_W-1:0];
    endfunction

endpackage

// File: rtl/endec_stream_host_if.sv
// TX/RX AXI4-Stream pair between the host and the endec core.
// master = host side (drives TX, sinks RX); slave = core side.
interface endec_stream_host_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] axi_tx_tdata;
    logic              axi_tx_tvalid;
    logic              axi_tx_tlast;
    logic              axi_tx_tready;
    logic [DATA_W-1:0] axi_rx_tdata;
    logic              axi_rx_tvalid;
    logic              axi_rx_tlast;
    logic              axi_rx_tready;

    modport master (
        output axi_tx_tdata, axi_tx_tvalid, axi_tx_tlast, axi_rx_tready,
        input  axi_tx_tready, axi_rx_tdata, axi_rx_tvalid, axi_rx_tlast
    );

    modport slave (
        input  axi_tx_tdata, axi_tx_tvalid, axi_tx_tlast, axi_rx_tready,
        output axi_tx_tready, axi_rx_tdata, axi_rx_tvalid, axi_rx_tlast
    );
endinterface

// File: rtl/endec_host_wdog.sv
// RX idle watchdog: counts cycles while running without a kick.
// Latency: o_expired is high in the LIMIT-th idle cycle after the last kick.
// Backpressure: none; the counter clears whenever i_run is low or i_kick is high.
module endec_host_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge sys_clk) begin
        if (rst || !i_run || i_kick) begin
            cnt_q <= '0;
        end else if (!o_expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expired = i_run && !i_kick && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/param_def.sv
// Shared widths and mode encodings for the convolutional encoder/decoder link.
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`define MAX_CONSTRAINT_LENGTH 9
`define MAX_CODE_RATE         3
`define ENCODE_MODE           1'b0
`define DECODE_MODE           1'b1
`endif

// File: rtl/endec_stream_host.sv
// Host-side stream driver: sends config + payload packets, collects the response into o_result.
// Latency: 18 cycles start-to-o_done with both sides always ready; optional RX watchdog under ENDEC_HOST_TIMEOUT_EN.
// Backpressure: TX beats hold until tready; RX tready only in RESP; trailing RX beats are never accepted.
module endec_stream_host
    import endec_host_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_mode_sel,
    input  logic                i_code_rate,
    input  logic [POLY_W-1:0]   i_gen_poly_flat,
    input  logic [FRAME_W-1:0]  i_frame,
    endec_stream_host_if.master axis,
    output logic [FRAME_W-1:0]  o_result,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_timeout
);

    state_e             state_q;
    logic               dec_q;
    logic [FRAME_W-1:0] frame_q;
    logic [3:0]         cnt_q;
    logic [DATA_W-1:0]  tx_dat_q;
    logic               tx_vld_q;
    logic               tx_last_q;
    logic               rx_rdy_q;
    logic [FRAME_W-1:0] result_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               timeout_q;

    logic       tx_hs;
    logic       rx_hs;
    logic       wdog_expired;
    logic [3:0] tx_last_idx;
    logic [3:0] rx_last_idx;
    int         tx_span;
    logic [8:0] rx_lsb;

    assign tx_hs       = tx_vld_q && axis.axi_tx_tready;
    assign rx_hs       = rx_rdy_q && axis.axi_rx_tvalid;
    assign tx_last_idx = dec_q ? (DEC_TX_BEATS - 4'd1) : (ENC_TX_BEATS - 4'd1);
    assign rx_last_idx = dec_q ? (DEC_RX_BEATS - 4'd1) : (ENC_RX_BEATS - 4'd1);
    assign tx_span     = dec_q ? 384 : 128;
    // Response lands MSB-first in the top R bits of the result (R = 128 decode, 384 encode).
    assign rx_lsb      = 9'((dec_q ? 128 : 384) - BEAT_W * (int'(cnt_q) + 1));

`ifdef ENDEC_HOST_TIMEOUT_EN
    endec_host_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .i_run     (rx_rdy_q),
        .i_kick    (rx_hs),
        .o_expired (wdog_expired)
    );
`else
    // No watchdog built: RESP waits for the source indefinitely.
    assign wdog_expired = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dec_q     <= 1'b0;
            frame_q   <= '0;
            cnt_q     <= '0;
            tx_dat_q  <= '0;
            tx_vld_q  <= 1'b0;
            tx_last_q <= 1'b0;
            rx_rdy_q  <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        dec_q     <= (i_mode_sel == `DECODE_MODE);
                        frame_q   <= i_frame;
                        err_q     <= 1'b0;
                        timeout_q <= 1'b0;
                        result_q  <= '0;
                        tx_dat_q  <= cfg_word(i_mode_sel, i_code_rate, i_gen_poly_flat);
                        tx_vld_q  <= 1'b1;
                        tx_last_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CONF;
                    end
                end
                ST_CONF: begin
                    if (tx_hs) begin
                        tx_dat_q  <= frame_beat(frame_q, tx_span, 4'd0);
                        tx_last_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (tx_hs) begin
                        if (cnt_q == tx_last_idx) begin
                            tx_vld_q  <= 1'b0;
                            tx_last_q <= 1'b0;
                            tx_dat_q  <= '0;
                            cnt_q     <= '0;
                            rx_rdy_q  <= 1'b1;
                            state_q   <= ST_RESP;
                        end else begin
                            cnt_q     <= cnt_q + 4'd1;
                            tx_dat_q  <= frame_beat(frame_q, tx_span, cnt_q + 4'd1);
                            tx_last_q <= ((cnt_q + 4'd1) == tx_last_idx);
                        end
                    end
                end
                ST_RESP: begin
                    if (rx_hs) begin
                        result_q[rx_lsb +: BEAT_W] <= axis.axi_rx_tdata;
                        // Either the expected last beat or an early tlast ends the packet.
                        if (cnt_q == rx_last_idx || axis.axi_rx_tlast) begin
                            err_q    <= !(cnt_q == rx_last_idx && axis.axi_rx_tlast);
                            rx_rdy_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else if (wdog_expired) begin
                        timeout_q <= 1'b1;
                        rx_rdy_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axis.axi_tx_tdata  = tx_dat_q;
    assign axis.axi_tx_tvalid = tx_vld_q;
    assign axis.axi_tx_tlast  = tx_last_q;
    assign axis.axi_rx_tready = rx_rdy_q;
    assign o_result           = result_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_err              = err_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_endec_stream_host.sv
// Directed + randomized bench for endec_stream_host; plays both the TX sink and the RX source.
module tb_endec_stream_host;

`ifdef ENDEC_HOST_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic         sys_clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_mode_sel = 1'b0;
    logic         i_code_rate = 1'b0;
    logic [26:0]  i_gen_poly_flat = '0;
    logic [383:0] i_frame = '0;
    logic [383:0] o_result;
    logic         o_busy, o_done, o_err, o_timeout;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rx_src [16];

    always #5 sys_clk = ~sys_clk;

    endec_stream_host_if #(.DATA_W(32)) axis ();

    endec_stream_host #(.DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_mode_sel      (i_mode_sel),
        .i_code_rate     (i_code_rate),
        .i_gen_poly_flat (i_gen_poly_flat),
        .i_frame         (i_frame),
        .axis            (axis),
        .o_result        (o_result),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_timeout       (o_timeout)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] rand384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, {axis.axi_tx_tvalid, axis.axi_tx_tlast, axis.axi_tx_tdata,
                            axis.axi_rx_tready, o_busy, o_done, o_err, o_timeout}, '0);
        chk({tag, " result"}, o_result, '0);
    endtask

    // tx_pat: 0 always ready, 1 toggling 1-0-1-0, 2 random. exp_done < 0 skips the latency check.
    task automatic run_txn(input string tag, input logic dec, input logic rate,
                           input logic [26:0] poly, input logic [383:0] frame,
                           input int rx_n, input int tlast_at, input int tx_pat,
                           input bit rx_gaps, input int exp_done);
        logic [32:0]  exp_tx[$];
        logic [32:0]  got_tx[$];
        logic [32:0]  prev_beat;
        logic [383:0] exp_res, sh;
        int  w, r, nrx, acc, cyc, done_cyc, last_rx_cyc, rx_idx, n;
        bit  exp_err, exp_to, prev_stall, tr, rv, hs_tx, hs_rx;

        // Reference model: packets straight from the framing rules.
        w = dec ? 384 : 128;
        r = dec ? 128 : 384;
        nrx = dec ? 4 : 12;
        exp_tx.push_back({1'b1, 2'b00, dec, rate, 1'b0, poly});
        for (int k = 0; k < w / 32; k++) begin
            sh = frame >> (w - 32 * (k + 1));
            exp_tx.push_back({(k == w / 32 - 1), sh[31:0]});
        end
        acc = 0; exp_err = 0; exp_to = 0; exp_res = '0;
        for (int k = 0; k < nrx; k++) begin
            if (k >= rx_n) begin
                exp_to = 1;
                break;
            end
            acc++;
            exp_res = exp_res | ({352'b0, rx_src[k]} << (r - 32 * (k + 1)));
            if (k == tlast_at || k == nrx - 1) begin
                exp_err = (k != nrx - 1) || (k != tlast_at);
                break;
            end
        end

        i_mode_sel = dec; i_code_rate = rate; i_gen_poly_flat = poly; i_frame = frame;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_mode_sel = ~dec; i_code_rate = ~rate; i_gen_poly_flat = ~poly; i_frame = ~frame;
        cyc = 1; done_cyc = 0; last_rx_cyc = 0; rx_idx = 0; prev_stall = 0; prev_beat = '0;
        chk({tag, " cfg valid"}, {o_busy, axis.axi_tx_tvalid}, 2'b11);

        while (done_cyc == 0 && cyc < 300) begin
            if (prev_stall)
                chk({tag, " tx hold"}, {axis.axi_tx_tvalid, axis.axi_tx_tlast, axis.axi_tx_tdata},
                    {1'b1, prev_beat});
            case (tx_pat)
                0:       tr = 1'b1;
                1:       tr = (cyc % 2 == 1);
                default: tr = ($urandom_range(1) == 1);
            endcase
            rv = (rx_idx < rx_n) && (!rx_gaps || $urandom_range(3) != 0);
            axis.axi_tx_tready = tr;
            axis.axi_rx_tvalid = rv;
            axis.axi_rx_tdata  = rx_src[rx_idx % 16];
            axis.axi_rx_tlast  = rv && (rx_idx == tlast_at);
            hs_tx = axis.axi_tx_tvalid && tr;
            hs_rx = axis.axi_rx_tready && rv;
            prev_stall = axis.axi_tx_tvalid && !tr;
            prev_beat = {axis.axi_tx_tlast, axis.axi_tx_tdata};
            if (hs_tx) got_tx.push_back({axis.axi_tx_tlast, axis.axi_tx_tdata});
            tick();
            cyc++;
            if (hs_rx) begin
                rx_idx++;
                last_rx_cyc = cyc;
            end
            if (o_done) done_cyc = cyc;
        end

        chk({tag, " tx beats"}, got_tx.size(), exp_tx.size());
        n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
        for (int k = 0; k < n; k++) chk($sformatf("%s tx beat %0d", tag, k), got_tx[k], exp_tx[k]);

`ifndef ENDEC_HOST_TIMEOUT_EN
        if (exp_to) begin
            chk({tag, " still waiting"}, {done_cyc != 0, o_busy, axis.axi_rx_tready}, 3'b011);
            chk({tag, " rx partial"}, rx_idx, acc);
            axis.axi_rx_tvalid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_all_zero({tag, " recover"});
        end else
`endif
        begin
            chk({tag, " done seen"}, done_cyc != 0, 1'b1);
            chk({tag, " rx accepted"}, rx_idx, acc);
            if (exp_done > 0) chk({tag, " done cycle"}, done_cyc, exp_done);
            if (exp_to) chk({tag, " wdog delay"}, done_cyc - last_rx_cyc, TO_CYC);
            chk({tag, " result"}, o_result, exp_res);
            chk({tag, " err/to"}, {o_err, o_timeout}, {exp_err, exp_to});
            chk({tag, " rx_rdy low"}, axis.axi_rx_tready, 1'b0);
            tick();
            chk({tag, " post done"}, {o_done, o_busy, axis.axi_rx_tready}, 3'b000);
            chk({tag, " result hold"}, o_result, exp_res);
            chk({tag, " no trailing"}, rx_idx, acc);
        end
        axis.axi_rx_tvalid = 1'b0;
        axis.axi_rx_tlast = 1'b0;
        axis.axi_tx_tready = 1'b0;
    endtask

    initial begin
        logic [383:0] f, sh;
        int ndone;
        logic d;

        axis.axi_tx_tready = 1'b0;
        axis.axi_rx_tvalid = 1'b0;
        axis.axi_rx_tlast  = 1'b0;
        axis.axi_rx_tdata  = '0;
        for (int k = 0; k < 16; k++) rx_src[k] = '0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Encode, always ready on both sides.
        f = rand384();
        f[127:0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int k = 0; k < 12; k++) rx_src[k] = k;
        run_txn("enc", 1'b0, 1'b1, 27'h5A5A5A5, f, 12, 11, 0, 0, 18);

        // Decode with toggling TX backpressure; back-to-back start.
        for (int k = 0; k < 4; k++) rx_src[k] = 32'hDEADBEEF + k;
        run_txn("dec stall", 1'b1, 1'b0, $urandom, rand384(), 4, 3, 1, 0, -1);

        // Decode, minimum latency.
        run_txn("dec fast", 1'b1, 1'b1, $urandom, rand384(), 4, 3, 0, 0, 18);

        // Early tlast on RX beat 5 in encode.
        for (int k = 0; k < 12; k++) rx_src[k] = $urandom;
        run_txn("early tlast", 1'b0, 1'b0, $urandom, rand384(), 12, 5, 0, 0, -1);

        // Missing tlast in decode; two trailing beats offered must be refused.
        for (int k = 0; k < 8; k++) rx_src[k] = $urandom;
        run_txn("no tlast", 1'b1, 1'b1, $urandom, rand384(), 6, -1, 0, 0, -1);

        // Reset while payload beat 2 is on the bus.
        f = rand384();
        i_mode_sel = 1'b1; i_code_rate = 1'b0; i_gen_poly_flat = $urandom; i_frame = f;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        axis.axi_tx_tready = 1'b1;
        repeat (3) tick();
        sh = f >> (384 - 96);
        chk("rst beat2", {axis.axi_tx_tvalid, axis.axi_tx_tdata}, {1'b1, sh[31:0]});
        rst = 1'b1;
        tick();
        chk_all_zero("rst mid");
        rst = 1'b0;
        axis.axi_tx_tready = 1'b0;
        ndone = 0;
        repeat (20) begin
            tick();
            ndone += int'(o_done);
        end
        chk("rst no done", ndone, 0);
        for (int k = 0; k < 4; k++) rx_src[k] = $urandom;
        run_txn("after rst", 1'b1, 1'b0, $urandom, rand384(), 4, 3, 0, 0, 18);

        // RX source goes silent after 3 beats.
        for (int k = 0; k < 12; k++) rx_src[k] = $urandom;
        run_txn("wdog", 1'b0, 1'b1, $urandom, rand384(), 3, -1, 0, 0, -1);

        // Randomized transactions with random stalls and RX gaps.
        for (int t = 0; t < 6; t++) begin
            d = $urandom_range(1);
            for (int k = 0; k < 12; k++) rx_src[k] = $urandom;
            run_txn($sformatf("rand%0d", t), d, 1'($urandom_range(1)), $urandom, rand384(),
                    d ? 4 : 12, d ? 3 : 11, 2, 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/endec_stream_host.md
# endec_stream_host

Host-side AXI4-Stream master/slave that drives the convolutional encoder/decoder core's stream port. It latches a configuration word and a parallel frame, then sends one config packet and one payload packet as 32-bit beats, MSB-first. It then collects the response packet into a parallel result register. It sits on the test/host side of the stream link, so its TX connects to the core's RX and its RX connects to the core's TX.

## Interface
- `DATA_W`, 32: stream beat width; only 32 is supported.
- `TIMEOUT_CYC`, 1024: idle-cycle limit for the RX watchdog; used only when `ENDEC_HOST_TIMEOUT_EN` is defined.
- `sys_clk`, in, 1: single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `i_start`, in, 1: one-cycle request; sampled only in IDLE.
- `i_mode_sel`, in, 1: `ENCODE_MODE` or `DECODE_MODE`, as defined in param_def.sv.
- `i_code_rate`, in, 1: code-rate select, passed through in the config word.
- `i_gen_poly_flat`, in, 27 (`MAX_CONSTRAINT_LENGTH*`MAX_CODE_RATE`): generator polynomials.
- `i_frame`, in, 384: payload. Encode sends [127:0]; decode sends [383:0].
- `axi_tx_tdata`, out, 32 / `axi_tx_tvalid`, out, 1 / `axi_tx_tlast`, out, 1 / `axi_tx_tready`, in, 1: TX stream.
- `axi_rx_tdata`, in, 32 / `axi_rx_tvalid`, in, 1 / `axi_rx_tlast`, in, 1 / `axi_rx_tready`, out, 1: RX stream.
- `o_result`, out, 384: assembled response.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-cycle pulse when the transaction ends.
- `o_err`, out, 1: framing error; sticky until the next accepted `i_start`.
- `o_timeout`, out, 1: watchdog abort; sticky until the next accepted `i_start`. Tied 0 when the macro is absent.

## Operation
- States: IDLE → CONF → PAYLOAD → RESP → DONE → IDLE.
- **IDLE**
  - `i_start`=1 latches mode, rate, poly and frame into shadow registers.
  - It also clears `o_err`, `o_timeout` and `o_result`, then moves to CONF.
  - `i_start` outside IDLE is ignored.
- **CONF**: drives one beat with `tvalid`=1 and `tlast`=1.
  - tdata[29]=mode; tdata[28]=code_rate; tdata[27]=0; tdata[26:0]=poly; tdata[31:30]=0.
  - Moves to PAYLOAD on the `tvalid&tready` handshake.
- **PAYLOAD**: beat count is N_TX=4 (encode) or 12 (decode).
  - Beat k carries shadow bits [W-1-32k -: 32], where W=128 for encode and W=384 for decode.
  - `tlast`=1 on beat N_TX-1 only.
  - The beat counter is 4 bits wide and advances only on handshake.
  - Moves to RESP after the last handshake.
- **RESP**: `axi_rx_tready`=1; expected beat count is N_RX=12 (encode) or 4 (decode).
  - Beat k is written to `o_result`[R-1-32k -: 32], where R=384 for encode and R=128 for decode.
  - For decode, `o_result`[383:128] stays 0.
  - Normal end: the handshake on beat N_RX-1 carries `tlast`=1; go to DONE.
  - `tlast`=1 on an earlier beat: store that beat, set `o_err`, go to DONE.
  - Beat N_RX-1 without `tlast`: store it, set `o_err`, go to DONE. Trailing beats are not accepted.
- **DONE**: `o_done`=1 for one cycle, then IDLE.
- TX protocol rules:
  - Once `tvalid` rises, `tdata`, `tlast` and `tvalid` hold until `tready`.
  - `tvalid` never depends combinationally on `tready`.
- `axi_rx_tready` is 0 in every state except RESP.

## Timing
- Reset values: all outputs 0 and state IDLE, one edge after `rst`=1.
- `rst` mid-transaction aborts immediately: no `o_done`, and `tvalid` drops on the next edge.
- Accepted `i_start` at edge T gives the config beat `tvalid`=1 from T+1.
- With `tready` held high, TX runs one beat per cycle and PAYLOAD's first `tvalid` comes the cycle after the config handshake.
- `axi_rx_tready` rises the cycle after the last TX handshake.
- `o_done` is asserted the cycle after the final RX handshake. `o_result` and `o_err` are valid from that same cycle and hold until the next accepted `i_start`.
- Minimum transaction with both sides always ready:
  - encode: 1+4+12+1 = 18 cycles from start to `o_done`;
  - decode: 1+12+4+1 = 18 cycles.
- Back-to-back: `i_start` in the cycle after `o_done` (IDLE) is accepted.

## Configuration
- `ENDEC_HOST_TIMEOUT_EN` defined: an idle counter runs in RESP and resets on every RX handshake.
  - When it reaches `TIMEOUT_CYC` with no handshake: set `o_timeout`, go to DONE (`o_done` pulses).
  - Beats already received stay in `o_result`.
- Undefined: no counter is built, `o_timeout`=0, and RESP waits indefinitely.

## Structure
- Shared package `endec_host_pkg` holds:
  - the state enum;
  - beat-count constants: `ENC_TX_BEATS`=4, `DEC_TX_BEATS`=12, `ENC_RX_BEATS`=12, `DEC_RX_BEATS`=4;
  - config-word bit positions: `CFG_MODE_BIT`=29, `CFG_RATE_BIT`=28, `CFG_POLY_MSB`=26.
- Width macros and the mode values are taken from param_def.sv.
- One sub-module, `endec_host_wdog` (counter plus expiry flag), instantiated only under `ENDEC_HOST_TIMEOUT_EN`.

## Test plan
- **Encode, always-ready sink and source:**
  - Stimulus: mode=encode, rate=1, poly=27'h5A5A5A5, frame[127:0]=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210.
  - Config beat 32'h1_5A5A5A5 with `tlast`.
  - Payload 32'h01234567, 89ABCDEF, FEDCBA98, 76543210, with `tlast` on the 4th.
  - Feed 12 RX beats 32'h0000_0000..0000_000B with `tlast` on the last.
  - Required: `o_result`=beat0 at [383:352] … beat11 at [31:0], `o_done` at cycle 18, `o_err`=0.
- **Decode with TX backpressure:**
  - Stimulus: `tready` toggles 1-0-1-0 during 12 payload beats.
  - Required: `tdata` stable while stalled, 12 handshakes, then 4 RX beats 32'hDEADBEEF… land in `o_result`[127:0], with [383:128]=0.
- **Early `tlast` in encode RESP:**
  - Stimulus: `tlast` arrives on RX beat 5.
  - Required: 6 beats stored, `o_err`=1, `o_done` pulses, rest of `o_result` 0.
- **Missing `tlast`:**
  - Stimulus: 4 decode RX beats with `tlast`=0.
  - Required: `o_err`=1 after beat 3, `axi_rx_tready`=0 afterward.
- **Reset mid-PAYLOAD:**
  - Stimulus: `rst`=1 at beat 2 of the payload.
  - Required: next edge gives all outputs 0 and state IDLE; no `o_done`; a new `i_start` then completes normally.
- **Watchdog (macro defined, `TIMEOUT_CYC`=16):**
  - Stimulus: RX source silent after 3 beats.
  - Required: `o_timeout`=1 and `o_done` 16 cycles after the last handshake.
  - Without the macro, the bench still waits after 100 cycles.
